// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings and default widths.
package ifetch_pkg;

  localparam int unsigned DefPcW    = 9;
  localparam int unsigned DefInstrW = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StLoad  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifetch_imem.sv
// Single-port synchronous instruction RAM, one-cycle read latency; a write cycle leaves dout
// holding the previous read.
module ifetch_imem
  import ifetch_pkg::*;
#(
  parameter int unsigned PC_W    = DefPcW,
  parameter int unsigned INSTR_W = DefInstrW
) (
  input  logic               clk,
  input  logic               we,
  input  logic [PC_W-1:0]    addr,
  input  logic [INSTR_W-1:0] din,
  output logic [INSTR_W-1:0] dout
);

  localparam int unsigned Depth = 2 ** PC_W;

  logic [INSTR_W-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end else begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/ifetch_stream.sv
// Instruction-fetch stage: PC/FSM, one in-flight RAM read, 1-entry skid and valid/ready output.
// Define IFETCH_PERF_EN to add saturating transfer/stall counters.
module ifetch_stream
  import ifetch_pkg::*;
#(
  parameter int unsigned     PC_W     = DefPcW,
  parameter int unsigned     INSTR_W  = DefInstrW,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               host_we,
  input  logic [PC_W-1:0]    host_addr,
  input  logic [INSTR_W-1:0] host_wdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [1:0]         fetch_state
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  fetch_state_e       state_q;
  logic [PC_W-1:0]    pc_q, pc_d, fetch_addr, ram_addr;
  logic [PC_W-1:0]    infl_pc_q, skid_pc_q, out_pc_q;
  logic               infl_q, skid_valid_q, out_valid_q;
  logic [INSTR_W-1:0] ram_dout, skid_instr_q, out_instr_q;
  logic               stay_fetch, stall, issue;

  // Reads are only issued when the FSM stays in FETCH, so leaving FETCH never loses a pc.
  // A redirect reads its target in the same cycle; skid and out reg are squashed anyway.
  always_comb begin
    stay_fetch = (state_q == StFetch) && run && !host_we;
    stall      = out_valid_q && !out_ready;
    issue      = stay_fetch && (redirect_valid || (!skid_valid_q && !(infl_q && stall)));
    fetch_addr = redirect_valid ? redirect_pc : pc_q;
    ram_addr   = host_we ? host_addr : fetch_addr;
    pc_d       = issue ? fetch_addr + PC_W'(1) : fetch_addr;
  end

  ifetch_imem #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_imem (
    .clk  (clk),
    .we   (host_we),
    .addr (ram_addr),
    .din  (host_wdata),
    .dout (ram_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else if (host_we) begin
      state_q <= StLoad;
    end else begin
      unique case (state_q)
        StLoad:  state_q <= StIdle;
        StIdle:  if (run) state_q <= StFetch;
        StFetch: if (!run) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      infl_q       <= 1'b0;
      infl_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_instr_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      infl_q <= issue;
      if (issue) infl_pc_q <= fetch_addr;
      if (redirect_valid) begin
        out_valid_q  <= 1'b0;
        skid_valid_q <= 1'b0;
      end else if (!stall) begin
        // Skid is older than any in-flight return, so it drains first.
        if (skid_valid_q) begin
          out_valid_q  <= 1'b1;
          out_pc_q     <= skid_pc_q;
          out_instr_q  <= skid_instr_q;
          skid_valid_q <= infl_q;
          if (infl_q) begin
            skid_pc_q    <= infl_pc_q;
            skid_instr_q <= ram_dout;
          end
        end else if (infl_q) begin
          out_valid_q <= 1'b1;
          out_pc_q    <= infl_pc_q;
          out_instr_q <= ram_dout;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (infl_q) begin
        skid_valid_q <= 1'b1;
        skid_pc_q    <= infl_pc_q;
        skid_instr_q <= ram_dout;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_instr   = out_instr_q;
  assign fetch_state = state_q;

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;
  logic        xfer;

  assign xfer = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (xfer && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
